exc_sequencer: RTL and testbench
================================

Name: exc_sequencer

Overview:
- Consumer of the memory-stage protection checks (segment limit GP fault, paging PF fault) and the external interrupt line.
- On an accepted event it flushes the pipeline, waits for drain, pushes the return EIP, reads the IDT gate and redirects fetch.
- Sits between the MEM stage, the writeback/stack-push path and the fetch EIP mux.

Parameters:
- IDT_BASE, 32'h0000_0000, physical base of the interrupt descriptor table.
- GP_VEC, 8'h0D, vector used for a segment limit violation.
- PF_VEC, 8'h0E, vector used for a page fault.
- DF_VEC, 8'h08, vector used for a double fault.

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous active-high reset
- V_MEM  in  1  MEM-stage instruction valid
- EXC_GP  in  1  segment limit violation from MEM-stage limit check
- EXC_PF  in  1  page fault from MEM stage
- INT_REQ  in  1  external interrupt request (level)
- INT_VEC  in  8  external interrupt vector
- EIP_MEM  in  32  EIP of the MEM-stage instruction
- EIP_NEXT  in  32  EIP following the MEM-stage instruction
- WB_EMPTY  in  1  pipeline downstream of MEM is drained
- PUSH_ACK  in  1  stack push accepted
- PUSH_FAULT  in  1  stack push faulted (same cycle as PUSH_ACK)
- IDT_VALID  in  1  IDT read data valid
- IDT_DATA  in  32  handler offset from the gate
- FLUSH  out  1  one-cycle pipeline flush pulse
- STALL_FE  out  1  hold fetch/decode
- PUSH_REQ  out  1  request stack push
- PUSH_DATA  out  32  value to push
- IDT_RD  out  1  IDT read request
- IDT_ADDR  out  32  IDT_BASE + {vector, 3'b000}
- EIP_LOAD  out  1  one-cycle redirect pulse
- EIP_NEW  out  32  redirect target
- INT_ACK  out  1  one-cycle external interrupt acknowledge
- VECTOR  out  8  vector being serviced
- SHUTDOWN  out  1  triple-fault halt indicator

Behaviour:
- Reset (async, RST=1): state IDLE; all outputs 0; saved EIP and VECTOR cleared.
- States: IDLE, DRAIN, PUSH, FETCH, LOAD, HALT. Encoding is in the package.
- IDLE:
  - fault = V_MEM & (EXC_GP | EXC_PF). Priority GP > PF > INT_REQ.
  - On fault: save EIP_MEM; VECTOR = GP_VEC or PF_VEC; FLUSH pulses the next cycle; go to DRAIN.
  - Else on INT_REQ & V_MEM: save EIP_NEXT; VECTOR = INT_VEC; INT_ACK pulses the next cycle; FLUSH pulses; go to DRAIN.
  - INT_REQ while V_MEM=0 is held off.
- DRAIN: wait for WB_EMPTY=1; then go to PUSH. WB_EMPTY already high on entry still costs one cycle in DRAIN.
- PUSH:
  - PUSH_REQ=1 and PUSH_DATA=saved EIP, held until PUSH_ACK.
  - PUSH_ACK & ~PUSH_FAULT: go to FETCH.
  - PUSH_ACK & PUSH_FAULT:
    - VECTOR≠DF_VEC: VECTOR=DF_VEC, saved EIP unchanged, re-enter PUSH.
    - VECTOR=DF_VEC: go to HALT.
- FETCH: IDT_RD=1, IDT_ADDR=IDT_BASE+(VECTOR<<3) with 32-bit wrap, held until IDT_VALID; latch IDT_DATA.
- LOAD: EIP_LOAD=1 and EIP_NEW=latched offset for exactly one cycle; return to IDLE.
- HALT: SHUTDOWN=1, STALL_FE=1; only RST exits.
- STALL_FE=1 in every state except IDLE.
- EXC_GP, EXC_PF and INT_REQ are ignored outside IDLE. The flushed pipeline cannot legally raise them.
- The first IDLE cycle after LOAD may accept a new event (back-to-back allowed).
- Latency, fault in IDLE to EIP_LOAD with zero-wait responders: 5 cycles (DRAIN, PUSH, FETCH, LOAD entries plus the FLUSH cycle).
- Reset asserted mid-sequence aborts immediately. No partial push or redirect is emitted after release.

Optional Feature:
- Macro EXC_ERRCODE_EN.
- Defined:
  - GP, PF and DF push an error code word of 32'h0 after the EIP word, via a second PUSH beat (sub-state PUSH_ERR) before FETCH.
  - External interrupts never push an error code.
  - A PUSH_FAULT on either beat follows the double-fault rules, restarting at the EIP beat.
- Undefined: the single EIP push only; the PUSH_ERR state does not exist.

Decomposition:
- Package exc_pkg holds:
  - state encoding constants (IDLE=3'd0 … HALT=3'd5, PUSH_ERR=3'd6);
  - default vector constants GP/PF/DF;
  - gate size shift (3).
- One sub-module, exc_prio_sel: combinational priority select of the event and vector (GP > PF > INT), returning the valid bit, vector and EIP select.
- The FSM and registers stay in exc_sequencer.

Test Plan:
- GP fault: V_MEM=1, EXC_GP=1, EIP_MEM=32'h0000_1234, IDT_DATA=32'h0000_8000, zero-wait responders.
  - FLUSH next cycle; PUSH_DATA=32'h1234; IDT_ADDR=32'h68.
  - EIP_LOAD with EIP_NEW=32'h8000 five cycles after the fault.
- GP and PF together with INT_REQ=1: VECTOR=8'h0D, INT_ACK never asserted, INT serviced after return to IDLE.
- External interrupt: INT_VEC=8'h20, EIP_NEXT=32'h2004.
  - INT_ACK pulse; PUSH_DATA=32'h2004; IDT_ADDR=32'h100.
- Double and triple fault:
  - PF then PUSH_FAULT: VECTOR→8'h08 and PUSH re-issued.
  - Second PUSH_FAULT: SHUTDOWN=1 stays high.
  - RST clears SHUTDOWN.
- Handshake stalls and reset:
  - WB_EMPTY low 4 cycles and IDT_VALID delayed 3 cycles: outputs held stable, single EIP_LOAD.
  - RST pulsed during FETCH: all outputs 0, IDLE.
- With EXC_ERRCODE_EN: GP pushes 32'h1234 then 32'h0 before IDT_RD; INT pushes one word only.

Source files
------------

// File: rtl/exc_sequencer_pkg.sv
// exc_pkg: state encoding, default vectors and gate geometry for exc_sequencer.
// Shared by exc_prio_sel and exc_sequencer (optional error-code beat: EXC_ERRCODE_EN).
package exc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_PUSH     = 3'd2,
    ST_FETCH    = 3'd3,
    ST_LOAD     = 3'd4,
    ST_HALT     = 3'd5,
    ST_PUSH_ERR = 3'd6
  } exc_state_e;

  localparam logic [7:0] VEC_GP = 8'h0D;
  localparam logic [7:0] VEC_PF = 8'h0E;
  localparam logic [7:0] VEC_DF = 8'h08;

  localparam int GATE_SHIFT = 3;

  function automatic logic [31:0] gate_addr(
    input logic [31:0] base,
    input logic [7:0]  vec
  );
    return base + ({24'd0, vec} << GATE_SHIFT);
  endfunction

endpackage

// File: rtl/exc_sequencer_if.sv
// exc_sequencer_if: MEM-stage events, push/IDT handshakes and redirect outputs.
// master = sequencer side, slave = pipeline/memory side.
interface exc_sequencer_if;
  logic        V_MEM;
  logic        EXC_GP;
  logic        EXC_PF;
  logic        INT_REQ;
  logic [7:0]  INT_VEC;
  logic [31:0] EIP_MEM;
  logic [31:0] EIP_NEXT;
  logic        WB_EMPTY;
  logic        PUSH_ACK;
  logic        PUSH_FAULT;
  logic        IDT_VALID;
  logic [31:0] IDT_DATA;
  logic        FLUSH;
  logic        STALL_FE;
  logic        PUSH_REQ;
  logic [31:0] PUSH_DATA;
  logic        IDT_RD;
  logic [31:0] IDT_ADDR;
  logic        EIP_LOAD;
  logic [31:0] EIP_NEW;
  logic        INT_ACK;
  logic [7:0]  VECTOR;
  logic        SHUTDOWN;

  modport master (
    input  V_MEM, EXC_GP, EXC_PF, INT_REQ, INT_VEC,
    input  EIP_MEM, EIP_NEXT, WB_EMPTY,
    input  PUSH_ACK, PUSH_FAULT, IDT_VALID, IDT_DATA,
    output FLUSH, STALL_FE, PUSH_REQ, PUSH_DATA,
    output IDT_RD, IDT_ADDR, EIP_LOAD, EIP_NEW,
    output INT_ACK, VECTOR, SHUTDOWN
  );

  modport slave (
    output V_MEM, EXC_GP, EXC_PF, INT_REQ, INT_VEC,
    output EIP_MEM, EIP_NEXT, WB_EMPTY,
    output PUSH_ACK, PUSH_FAULT, IDT_VALID, IDT_DATA,
    input  FLUSH, STALL_FE, PUSH_REQ, PUSH_DATA,
    input  IDT_RD, IDT_ADDR, EIP_LOAD, EIP_NEW,
    input  INT_ACK, VECTOR, SHUTDOWN
  );
endinterface

// File: rtl/exc_prio_sel.sv
// exc_prio_sel: picks GP > PF > INT among MEM-stage events.
// Out: ev_valid, ev_vec, ev_is_int (1 = return to EIP_NEXT).
module exc_prio_sel
  import exc_pkg::*;
#(
  parameter logic [7:0] GP_VEC = VEC_GP,
  parameter logic [7:0] PF_VEC = VEC_PF
) (
  input  logic       v_mem,
  input  logic       exc_gp,
  input  logic       exc_pf,
  input  logic       int_req,
  input  logic [7:0] int_vec,
  output logic       ev_valid,
  output logic       ev_is_int,
  output logic [7:0] ev_vec
);

  logic gp_hit;
  logic pf_hit;
  logic int_hit;

  // One-hot by construction so the decoder stays unique.
  assign gp_hit  = v_mem & exc_gp;
  assign pf_hit  = v_mem & exc_pf & ~exc_gp;
  assign int_hit = v_mem & int_req & ~exc_gp & ~exc_pf;

  always_comb begin
    ev_valid  = 1'b0;
    ev_is_int = 1'b0;
    ev_vec    = 8'd0;
    unique case (1'b1)
      gp_hit: begin
        ev_valid = 1'b1;
        ev_vec   = GP_VEC;
      end
      pf_hit: begin
        ev_valid = 1'b1;
        ev_vec   = PF_VEC;
      end
      int_hit: begin
        ev_valid  = 1'b1;
        ev_is_int = 1'b1;
        ev_vec    = int_vec;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/exc_sequencer.sv
// exc_sequencer: flush, drain, push return EIP, read IDT gate, redirect fetch.
// Ports: CLK, RST (async high), bus (exc_sequencer_if.master); EXC_ERRCODE_EN adds an error-code beat.
module exc_sequencer
  import exc_pkg::*;
#(
  parameter logic [31:0] IDT_BASE = 32'h0000_0000,
  parameter logic [7:0]  GP_VEC   = VEC_GP,
  parameter logic [7:0]  PF_VEC   = VEC_PF,
  parameter logic [7:0]  DF_VEC   = VEC_DF
) (
  input  logic             CLK,
  input  logic             RST,
  exc_sequencer_if.master  bus
);

  exc_state_e  state_q, state_d;
  logic [31:0] eip_q, eip_d;
  logic [7:0]  vec_q, vec_d;
  logic [31:0] off_q, off_d;
  logic        flush_q, flush_d;
  logic        ack_q, ack_d;
`ifdef EXC_ERRCODE_EN
  logic        is_int_q, is_int_d;
`endif

  logic        ev_valid;
  logic        ev_is_int;
  logic [7:0]  ev_vec;

  exc_prio_sel #(
    .GP_VEC (GP_VEC),
    .PF_VEC (PF_VEC)
  ) u_prio (
    .v_mem     (bus.V_MEM),
    .exc_gp    (bus.EXC_GP),
    .exc_pf    (bus.EXC_PF),
    .int_req   (bus.INT_REQ),
    .int_vec   (bus.INT_VEC),
    .ev_valid  (ev_valid),
    .ev_is_int (ev_is_int),
    .ev_vec    (ev_vec)
  );

  always_comb begin
    state_d = state_q;
    eip_d   = eip_q;
    vec_d   = vec_q;
    off_d   = off_q;
    flush_d = 1'b0;
    ack_d   = 1'b0;
`ifdef EXC_ERRCODE_EN
    is_int_d = is_int_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (ev_valid) begin
          eip_d   = ev_is_int ? bus.EIP_NEXT
                              : bus.EIP_MEM;
          vec_d   = ev_vec;
          flush_d = 1'b1;
          ack_d   = ev_is_int;
`ifdef EXC_ERRCODE_EN
          is_int_d = ev_is_int;
`endif
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The flush cycle itself never counts as drained.
        if (!flush_q && bus.WB_EMPTY)
          state_d = ST_PUSH;
      end
      ST_PUSH: begin
        if (bus.PUSH_ACK) begin
          if (bus.PUSH_FAULT) begin
            if (vec_q == DF_VEC) begin
              state_d = ST_HALT;
            end else begin
              vec_d = DF_VEC;
`ifdef EXC_ERRCODE_EN
              is_int_d = 1'b0;
`endif
            end
          end else begin
`ifdef EXC_ERRCODE_EN
            state_d = is_int_q ? ST_FETCH
                               : ST_PUSH_ERR;
`else
            state_d = ST_FETCH;
`endif
          end
        end
      end
`ifdef EXC_ERRCODE_EN
      ST_PUSH_ERR: begin
        if (bus.PUSH_ACK) begin
          if (bus.PUSH_FAULT) begin
            // Restart the frame at the EIP beat.
            if (vec_q == DF_VEC) begin
              state_d = ST_HALT;
            end else begin
              vec_d   = DF_VEC;
              state_d = ST_PUSH;
            end
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
`endif
      ST_FETCH: begin
        if (bus.IDT_VALID) begin
          off_d   = bus.IDT_DATA;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: state_d = ST_IDLE;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      eip_q   <= '0;
      vec_q   <= '0;
      off_q   <= '0;
      flush_q <= 1'b0;
      ack_q   <= 1'b0;
`ifdef EXC_ERRCODE_EN
      is_int_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      eip_q   <= eip_d;
      vec_q   <= vec_d;
      off_q   <= off_d;
      flush_q <= flush_d;
      ack_q   <= ack_d;
`ifdef EXC_ERRCODE_EN
      is_int_q <= is_int_d;
`endif
    end
  end

  always_comb begin
    bus.FLUSH     = flush_q;
    bus.INT_ACK   = ack_q;
    bus.VECTOR    = vec_q;
    bus.STALL_FE  = (state_q != ST_IDLE);
    bus.PUSH_REQ  = 1'b0;
    bus.PUSH_DATA = 32'd0;
    bus.IDT_RD    = 1'b0;
    bus.IDT_ADDR  = 32'd0;
    bus.EIP_LOAD  = 1'b0;
    bus.EIP_NEW   = 32'd0;
    bus.SHUTDOWN  = 1'b0;
    unique case (state_q)
      ST_PUSH: begin
        bus.PUSH_REQ  = 1'b1;
        bus.PUSH_DATA = eip_q;
      end
      ST_PUSH_ERR: bus.PUSH_REQ = 1'b1;
      ST_FETCH: begin
        bus.IDT_RD   = 1'b1;
        bus.IDT_ADDR = gate_addr(IDT_BASE, vec_q);
      end
      ST_LOAD: begin
        bus.EIP_LOAD = 1'b1;
        bus.EIP_NEW  = off_q;
      end
      ST_HALT: bus.SHUTDOWN = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_exc_sequencer.sv
// tb_exc_sequencer: scenario tasks with a push/IDT/redirect scoreboard.
// Drives exc_sequencer through exc_sequencer_if with zero-wait or delayed responders.
`timescale 1ns/1ps
module tb_exc_sequencer;

`ifdef EXC_ERRCODE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 5;
`endif

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  exc_sequencer_if bus();

  exc_sequencer dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int beats_q    = 0;
  int fault_upto = 0;
  int idt_wait   = 0;
  int idt_cnt    = 0;

  int flush_n = 0;
  int ack_n   = 0;
  int load_n  = 0;
  int last_flush = 0;
  int last_load  = 0;

  logic [31:0] exp_push[$];
  logic [31:0] exp_idt[$];
  logic [31:0] exp_load[$];

  always_comb begin
    bus.PUSH_ACK   = bus.PUSH_REQ;
    bus.PUSH_FAULT = bus.PUSH_REQ &&
                     (beats_q < fault_upto);
    bus.IDT_VALID  = bus.IDT_RD &&
                     (idt_cnt >= idt_wait);
  end

  always @(posedge CLK) begin
    idt_cnt <= bus.IDT_RD ? idt_cnt + 1 : 0;
    if (bus.PUSH_REQ && bus.PUSH_ACK)
      beats_q <= beats_q + 1;
  end

  // One cycle: sample at negedge and score the
  // push, gate read and redirect events.
  task automatic tick();
    logic [31:0] e;
    @(negedge CLK);
    cyc++;
    if (bus.FLUSH) begin
      flush_n++;
      last_flush = cyc;
    end
    if (bus.INT_ACK) ack_n++;
    if (bus.PUSH_REQ && bus.PUSH_ACK) begin
      total++;
      if (exp_push.size() == 0) begin
        bad++;
        $display("FAIL push_extra got=%h want=none",
                 bus.PUSH_DATA);
      end else begin
        e = exp_push.pop_front();
        if (bus.PUSH_DATA !== e) begin
          bad++;
          $display("FAIL push_data got=%h want=%h",
                   bus.PUSH_DATA, e);
        end
      end
    end
    if (bus.IDT_RD && bus.IDT_VALID) begin
      total++;
      if (exp_idt.size() == 0) begin
        bad++;
        $display("FAIL idt_extra got=%h want=none",
                 bus.IDT_ADDR);
      end else begin
        e = exp_idt.pop_front();
        if (bus.IDT_ADDR !== e) begin
          bad++;
          $display("FAIL idt_addr got=%h want=%h",
                   bus.IDT_ADDR, e);
        end
      end
    end
    if (bus.EIP_LOAD) begin
      load_n++;
      last_load = cyc;
      total++;
      if (exp_load.size() == 0) begin
        bad++;
        $display("FAIL load_extra got=%h want=none",
                 bus.EIP_NEW);
      end else begin
        e = exp_load.pop_front();
        if (bus.EIP_NEW !== e) begin
          bad++;
          $display("FAIL eip_new got=%h want=%h",
                   bus.EIP_NEW, e);
        end
      end
    end
  endtask

  task automatic run_to_load(input int n,
                             output bit hit);
    int start;
    start = load_n;
    hit = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (load_n > start) begin
        hit = 1'b1;
        break;
      end
    end
  endtask

  task automatic clear_ev();
    bus.V_MEM   = 1'b0;
    bus.EXC_GP  = 1'b0;
    bus.EXC_PF  = 1'b0;
    bus.INT_REQ = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    clear_ev();
    bus.INT_VEC  = 8'h0;
    bus.EIP_MEM  = 32'h0;
    bus.EIP_NEXT = 32'h0;
    bus.WB_EMPTY = 1'b1;
    bus.IDT_DATA = 32'h0;
    tick();
    tick();
    total++;
    if ({bus.FLUSH, bus.STALL_FE, bus.PUSH_REQ,
         bus.IDT_RD, bus.EIP_LOAD, bus.INT_ACK,
         bus.SHUTDOWN} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctl got=%b want=0",
               {bus.FLUSH, bus.STALL_FE,
                bus.PUSH_REQ, bus.IDT_RD,
                bus.EIP_LOAD, bus.INT_ACK,
                bus.SHUTDOWN});
    end
    total++;
    if ({bus.PUSH_DATA, bus.IDT_ADDR, bus.EIP_NEW,
         bus.VECTOR} !== 104'd0) begin
      bad++;
      $display("FAIL reset_data got=%h/%h/%h/%h want=0",
               bus.PUSH_DATA, bus.IDT_ADDR,
               bus.EIP_NEW, bus.VECTOR);
    end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_gp();
    int t0;
    bit hit;
    exp_push.push_back(32'h0000_1234);
`ifdef EXC_ERRCODE_EN
    exp_push.push_back(32'h0);
`endif
    exp_idt.push_back(32'h68);
    exp_load.push_back(32'h0000_8000);
    bus.IDT_DATA = 32'h0000_8000;
    bus.EIP_MEM  = 32'h0000_1234;
    bus.EIP_NEXT = 32'h0000_1238;
    bus.V_MEM    = 1'b1;
    bus.EXC_GP   = 1'b1;
    t0 = cyc;
    tick();
    clear_ev();
    total++;
    if (bus.FLUSH !== 1'b1 || bus.VECTOR !== 8'h0D) begin
      bad++;
      $display("FAIL gp_flush got=%b/%h want=1/0d",
               bus.FLUSH, bus.VECTOR);
    end
    run_to_load(20, hit);
    total++;
    if (!hit || last_load != t0 + LAT) begin
      bad++;
      $display("FAIL gp_latency got=%0d want=%0d",
               last_load - t0, LAT);
    end
    total++;
    if (exp_push.size() + exp_idt.size() +
        exp_load.size() != 0) begin
      bad++;
      $display("FAIL gp_left got=%0d want=0",
               exp_push.size() + exp_idt.size() +
               exp_load.size());
    end
    tick();
  endtask

  task automatic test_prio();
    int a0, l1;
    bit hit;
    exp_push.push_back(32'h0000_3000);
`ifdef EXC_ERRCODE_EN
    exp_push.push_back(32'h0);
`endif
    exp_idt.push_back(32'h68);
    exp_load.push_back(32'h0000_A000);
    bus.IDT_DATA = 32'h0000_A000;
    bus.EIP_MEM  = 32'h0000_3000;
    bus.EIP_NEXT = 32'h0000_3004;
    bus.INT_VEC  = 8'h20;
    bus.V_MEM    = 1'b1;
    bus.EXC_GP   = 1'b1;
    bus.EXC_PF   = 1'b1;
    bus.INT_REQ  = 1'b1;
    a0 = ack_n;
    tick();
    bus.EXC_GP = 1'b0;
    bus.EXC_PF = 1'b0;
    total++;
    if (bus.VECTOR !== 8'h0D) begin
      bad++;
      $display("FAIL prio_vec got=%h want=0d",
               bus.VECTOR);
    end
    run_to_load(20, hit);
    l1 = last_load;
    total++;
    if (!hit || ack_n != a0) begin
      bad++;
      $display("FAIL prio_noack got=%0d/%0d want=1/0",
               hit, ack_n - a0);
    end
    exp_push.push_back(32'h0000_3004);
    exp_idt.push_back(32'h100);
    exp_load.push_back(32'h0000_A000);
    run_to_load(20, hit);
    clear_ev();
    total++;
    if (!hit || ack_n != a0 + 1 ||
        bus.VECTOR !== 8'h20) begin
      bad++;
      $display("FAIL prio_int got=%0d/%0d/%h want=1/1/20",
               hit, ack_n - a0, bus.VECTOR);
    end
    total++;
    if (last_flush != l1 + 2) begin
      bad++;
      $display("FAIL b2b_flush got=%0d want=%0d",
               last_flush, l1 + 2);
    end
    tick();
  endtask

  task automatic test_int();
    int f0, a0;
    bit hit;
    bus.INT_VEC  = 8'h20;
    bus.EIP_NEXT = 32'h0000_2004;
    bus.EIP_MEM  = 32'h0000_2000;
    bus.IDT_DATA = 32'h0000_4000;
    bus.INT_REQ  = 1'b1;
    f0 = flush_n;
    a0 = ack_n;
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (flush_n != f0 || bus.STALL_FE !== 1'b0) begin
      bad++;
      $display("FAIL int_holdoff got=%0d/%b want=0/0",
               flush_n - f0, bus.STALL_FE);
    end
    exp_push.push_back(32'h0000_2004);
    exp_idt.push_back(32'h100);
    exp_load.push_back(32'h0000_4000);
    bus.V_MEM = 1'b1;
    tick();
    clear_ev();
    total++;
    if (bus.INT_ACK !== 1'b1 || bus.FLUSH !== 1'b1) begin
      bad++;
      $display("FAIL int_ack got=%b/%b want=1/1",
               bus.INT_ACK, bus.FLUSH);
    end
    tick();
    total++;
    if (bus.INT_ACK !== 1'b0) begin
      bad++;
      $display("FAIL int_pulse got=%b want=0",
               bus.INT_ACK);
    end
    run_to_load(20, hit);
    total++;
    if (!hit || ack_n != a0 + 1 ||
        exp_push.size() != 0) begin
      bad++;
      $display("FAIL int_done got=%0d/%0d/%0d want=1/1/0",
               hit, ack_n - a0, exp_push.size());
    end
    tick();
  endtask

  task automatic test_double();
    bit hit;
    exp_push.push_back(32'h0000_5000);
    exp_push.push_back(32'h0000_5000);
`ifdef EXC_ERRCODE_EN
    exp_push.push_back(32'h0);
`endif
    exp_idt.push_back(32'h40);
    exp_load.push_back(32'h0000_6000);
    bus.IDT_DATA = 32'h0000_6000;
    bus.EIP_MEM  = 32'h0000_5000;
    fault_upto   = beats_q + 1;
    bus.V_MEM    = 1'b1;
    bus.EXC_PF   = 1'b1;
    tick();
    clear_ev();
    total++;
    if (bus.VECTOR !== 8'h0E) begin
      bad++;
      $display("FAIL df_pfvec got=%h want=0e",
               bus.VECTOR);
    end
    run_to_load(20, hit);
    total++;
    if (!hit || bus.VECTOR !== 8'h08 ||
        exp_push.size() != 0) begin
      bad++;
      $display("FAIL df_vec got=%0d/%h/%0d want=1/08/0",
               hit, bus.VECTOR, exp_push.size());
    end
    tick();
  endtask

  task automatic test_triple();
    int l0;
    exp_push.push_back(32'h0000_7000);
    exp_push.push_back(32'h0000_7000);
    bus.EIP_MEM = 32'h0000_7000;
    fault_upto  = beats_q + 2;
    bus.V_MEM   = 1'b1;
    bus.EXC_PF  = 1'b1;
    l0 = load_n;
    tick();
    clear_ev();
    for (int i = 0; i < 12; i++) tick();
    total++;
    if (bus.SHUTDOWN !== 1'b1 || bus.STALL_FE !== 1'b1 ||
        bus.VECTOR !== 8'h08 || load_n != l0) begin
      bad++;
      $display("FAIL tf_halt got=%b/%b/%h/%0d want=1/1/08/0",
               bus.SHUTDOWN, bus.STALL_FE,
               bus.VECTOR, load_n - l0);
    end
    total++;
    if (exp_push.size() != 0 || bus.PUSH_REQ !== 1'b0) begin
      bad++;
      $display("FAIL tf_push got=%0d/%b want=0/0",
               exp_push.size(), bus.PUSH_REQ);
    end
    RST = 1'b1;
    tick();
    total++;
    if (bus.SHUTDOWN !== 1'b0 || bus.STALL_FE !== 1'b0) begin
      bad++;
      $display("FAIL tf_reset got=%b/%b want=0/0",
               bus.SHUTDOWN, bus.STALL_FE);
    end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_stalls();
    int l0, rd, unstable, held;
    bit hit;
    exp_push.push_back(32'h0000_9000);
`ifdef EXC_ERRCODE_EN
    exp_push.push_back(32'h0);
`endif
    exp_idt.push_back(32'h68);
    exp_load.push_back(32'h0000_B000);
    bus.IDT_DATA = 32'h0000_B000;
    bus.EIP_MEM  = 32'h0000_9000;
    bus.WB_EMPTY = 1'b0;
    idt_wait     = 3;
    bus.V_MEM    = 1'b1;
    bus.EXC_GP   = 1'b1;
    l0 = load_n;
    tick();
    clear_ev();
    held = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.PUSH_REQ !== 1'b0 || bus.STALL_FE !== 1'b1)
        held++;
    end
    total++;
    if (held != 0) begin
      bad++;
      $display("FAIL drain_hold got=%0d want=0", held);
    end
    bus.WB_EMPTY = 1'b1;
    rd = 0;
    unstable = 0;
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.IDT_RD) begin
        rd++;
        if (bus.IDT_ADDR !== 32'h68) unstable++;
      end
      if (load_n > l0) begin
        hit = 1'b1;
        break;
      end
    end
    total++;
    if (!hit || rd != 4 || unstable != 0) begin
      bad++;
      $display("FAIL idt_wait got=%0d/%0d/%0d want=1/4/0",
               hit, rd, unstable);
    end
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (load_n != l0 + 1) begin
      bad++;
      $display("FAIL single_load got=%0d want=1",
               load_n - l0);
    end
    idt_wait = 0;
  endtask

  task automatic test_reset_mid();
    int l0;
    bit seen;
    exp_push.push_back(32'h0000_C000);
`ifdef EXC_ERRCODE_EN
    exp_push.push_back(32'h0);
`endif
    bus.EIP_MEM = 32'h0000_C000;
    idt_wait    = 5;
    bus.V_MEM   = 1'b1;
    bus.EXC_GP  = 1'b1;
    l0 = load_n;
    tick();
    clear_ev();
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.IDT_RD) begin
        seen = 1'b1;
        break;
      end
    end
    tick();
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL mid_fetch got=0 want=1");
    end
    RST = 1'b1;
    #1;
    total++;
    if ({bus.FLUSH, bus.STALL_FE, bus.PUSH_REQ,
         bus.IDT_RD, bus.EIP_LOAD, bus.INT_ACK,
         bus.SHUTDOWN} !== 7'b0 ||
        {bus.PUSH_DATA, bus.IDT_ADDR, bus.EIP_NEW,
         bus.VECTOR} !== 104'd0) begin
      bad++;
      $display("FAIL mid_reset got=%b/%h want=0/0",
               {bus.FLUSH, bus.STALL_FE,
                bus.PUSH_REQ, bus.IDT_RD,
                bus.EIP_LOAD, bus.INT_ACK,
                bus.SHUTDOWN}, bus.VECTOR);
    end
    tick();
    RST = 1'b0;
    idt_wait = 0;
    for (int i = 0; i < 6; i++) tick();
    total++;
    if (load_n != l0 || bus.STALL_FE !== 1'b0 ||
        exp_push.size() != 0) begin
      bad++;
      $display("FAIL mid_after got=%0d/%b/%0d want=0/0/0",
               load_n - l0, bus.STALL_FE,
               exp_push.size());
    end
  endtask

  initial begin
    test_reset();
    test_gp();
    test_prio();
    test_int();
    test_double();
    test_triple();
    test_stalls();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=done");
    $fatal(1, "timeout");
  end

endmodule
